// File: rtl/sprite_anim_if.sv
`default_nettype none
// ============================================================================
// Module   : sprite_anim_if
// Brief    : Control, ROM and pixel-output bundle of the sprite engine.
// Revision : 1.0  initial release
// ============================================================================
interface sprite_anim_if #(
    parameter int WIDTH      = 8,
    parameter int HEIGHT     = 8,
    parameter int FRAMES     = 4,
    parameter int COLR_BITS  = 4,
    parameter int CORDW      = 16,
    parameter int SCALE_BITS = 3,
    parameter int ADDRW      = $clog2(WIDTH * HEIGHT * FRAMES),
    parameter int FRAME_BITS = (FRAMES > 1) ? $clog2(FRAMES) : 1
);
    logic                    start;
    logic                    enable;
    logic                    line_end;
    logic signed [CORDW-1:0] sx;
    logic signed [CORDW-1:0] sprx;
    logic [FRAME_BITS-1:0]   frame;
    logic                    flip_h;
    logic                    flip_v;
    logic [SCALE_BITS-1:0]   scale_x;
    logic [SCALE_BITS-1:0]   scale_y;
    logic [COLR_BITS-1:0]    data_in;
    logic [ADDRW-1:0]        addr;
    logic [COLR_BITS-1:0]    pix;
    logic                    drawing;
    logic                    busy;
    logic                    done;

    modport master (
        output start, enable, line_end, sx, sprx, frame, flip_h, flip_v,
               scale_x, scale_y, data_in,
        input  addr, pix, drawing, busy, done
    );

    modport slave (
        input  start, enable, line_end, sx, sprx, frame, flip_h, flip_v,
               scale_x, scale_y, data_in,
        output addr, pix, drawing, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/sprite_anim.sv
`default_nettype none
// ============================================================================
// Module   : sprite_anim
// Brief    : Line-synchronous sprite engine: walks a multi-frame sprite ROM and
//            emits scaled/flipped colour indices in lockstep with sx.
// Revision : 1.0  initial release
// ============================================================================
module sprite_anim #(
    parameter int WIDTH      = 8,
    parameter int HEIGHT     = 8,
    parameter int FRAMES     = 4,
    parameter int COLR_BITS  = 4,
    parameter int CORDW      = 16,
    parameter int SCALE_BITS = 3,
    parameter int LAT        = 2,
    parameter int TRANSP     = 0,
    parameter int ADDRW      = $clog2(WIDTH * HEIGHT * FRAMES)
) (
    input  wire             clk,
    input  wire             rst_n,
    sprite_anim_if.slave    bus
);

    localparam int c_XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int c_YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int c_FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_AWAIT     = 3'd2,
        S_DRAW      = 3'd3,
        S_NEXT_LINE = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [c_XW-1:0]         ox_q, ox_d;
    logic [c_YW-1:0]         oy_q, oy_d;
    logic [SCALE_BITS-1:0]   cx_q, cx_d;
    logic [SCALE_BITS-1:0]   cy_q, cy_d;
    logic [SCALE_BITS-1:0]   sx_scale_q, sx_scale_d;
    logic [SCALE_BITS-1:0]   sy_scale_q, sy_scale_d;
    logic [c_FW-1:0]         frame_q, frame_d;
    logic                    flip_h_q, flip_h_d;
    logic                    flip_v_q, flip_v_d;
    logic [ADDRW-1:0]        addr_q, addr_d;
    logic [LAT:0]            vld_q, vld_d;
    logic [COLR_BITS-1:0]    pix_q, pix_d;
    logic                    drawing_q, drawing_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    issue;
    logic [c_FW-1:0]         w_frame_in;
    logic signed [CORDW-1:0] w_match_x;
    logic                    w_match;
    logic                    w_last_cx;
    logic                    w_last_cy;
    logic                    w_last_col;
    logic                    w_last_row;
    logic [c_YW-1:0]         w_row;
    logic [c_XW-1:0]         w_col;
    logic [ADDRW-1:0]        w_addr;

    // Out-of-range frame numbers fold to frame 0; a power-of-two count cannot overflow.
    generate
        if ((1 << c_FW) == FRAMES) begin : g_frame_pow2
            assign w_frame_in = bus.frame;
        end else begin : g_frame_clamp
            assign w_frame_in = (int'(bus.frame) >= FRAMES) ? '0 : bus.frame;
        end
    endgenerate

    assign w_match_x  = bus.sprx - CORDW'(LAT + 2);
    assign w_match    = (bus.sx == w_match_x);
    assign w_last_cx  = (cx_q == sx_scale_q - SCALE_BITS'(1));
    assign w_last_cy  = (cy_q == sy_scale_q - SCALE_BITS'(1));
    assign w_last_col = (ox_q == c_XW'(WIDTH - 1)) && w_last_cx;
    assign w_last_row = (oy_q == c_YW'(HEIGHT - 1)) && w_last_cy;

    always_comb begin
        state_d    = state_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        sx_scale_d = sx_scale_q;
        sy_scale_d = sy_scale_q;
        frame_d    = frame_q;
        flip_h_d   = flip_h_q;
        flip_v_d   = flip_v_q;
        issue      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && bus.enable) state_d = S_START;
            end
            S_START: begin
                frame_d    = w_frame_in;
                flip_h_d   = bus.flip_h;
                flip_v_d   = bus.flip_v;
                sx_scale_d = (bus.scale_x == '0) ? SCALE_BITS'(1) : bus.scale_x;
                sy_scale_d = (bus.scale_y == '0) ? SCALE_BITS'(1) : bus.scale_y;
                oy_d       = '0;
                cy_d       = '0;
                state_d    = S_AWAIT;
            end
            S_AWAIT: begin
                // A real match wins over a coincident line_end so the row is drawn.
                if (w_match) begin
                    ox_d    = '0;
                    cx_d    = '0;
                    issue   = 1'b1;
                    state_d = S_DRAW;
                end else if (bus.line_end) begin
                    state_d = w_last_row ? S_DONE : S_NEXT_LINE;
                end
            end
            S_DRAW: begin
                if (w_last_col) begin
                    state_d = w_last_row ? S_DONE : S_NEXT_LINE;
                end else begin
                    issue = 1'b1;
                    if (w_last_cx) begin
                        cx_d = '0;
                        ox_d = ox_q + c_XW'(1);
                    end else begin
                        cx_d = cx_q + SCALE_BITS'(1);
                    end
                end
            end
            S_NEXT_LINE: begin
                if (w_last_cy) begin
                    cy_d = '0;
                    oy_d = oy_q + c_YW'(1);
                end else begin
                    cy_d = cy_q + SCALE_BITS'(1);
                end
                state_d = S_AWAIT;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ROM address comes from the next-state counters so it lands with the issue.
    assign w_row  = flip_v_q ? (c_YW'(HEIGHT - 1) - oy_d) : oy_d;
    assign w_col  = flip_h_q ? (c_XW'(WIDTH - 1) - ox_d) : ox_d;
    assign w_addr = ADDRW'(frame_q) * ADDRW'(WIDTH * HEIGHT)
                  + ADDRW'(w_row) * ADDRW'(WIDTH)
                  + ADDRW'(w_col);

    always_comb begin
        addr_d    = issue ? w_addr : addr_q;
        vld_d     = {vld_q[LAT-1:0], issue};
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        pix_d     = '0;
        drawing_d = 1'b0;
        // vld_q[LAT] marks the cycle in which data_in belongs to an issued address.
        if (vld_q[LAT] && (bus.data_in != COLR_BITS'(TRANSP))) begin
            pix_d     = bus.data_in;
            drawing_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ox_q       <= '0;
            oy_q       <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            sx_scale_q <= SCALE_BITS'(1);
            sy_scale_q <= SCALE_BITS'(1);
            frame_q    <= '0;
            flip_h_q   <= 1'b0;
            flip_v_q   <= 1'b0;
            addr_q     <= '0;
            vld_q      <= '0;
            pix_q      <= '0;
            drawing_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            sx_scale_q <= sx_scale_d;
            sy_scale_q <= sy_scale_d;
            frame_q    <= frame_d;
            flip_h_q   <= flip_h_d;
            flip_v_q   <= flip_v_d;
            addr_q     <= addr_d;
            vld_q      <= vld_d;
            pix_q      <= pix_d;
            drawing_q  <= drawing_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.addr    = addr_q;
    assign bus.pix     = pix_q;
    assign bus.drawing = drawing_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_anim.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_anim
// Brief    : Directed scoreboard bench for sprite_anim (8x8, 4 frames, LAT=2).
// Revision : 1.0  initial release
// ============================================================================
module tb_sprite_anim;

    localparam int LINE_LEN = 200;
    localparam int LAT      = 2;

    typedef struct {
        logic [4:0] pd;
        bit         chk_a;
        logic [7:0] a;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sprite_anim_if bus_if ();

    sprite_anim dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int   n_cmp    = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    int   done_base;
    int   rom_mode = 0;
    int   c_sxs, c_sys, c_fr, c_sprx;
    bit   c_fh, c_fv;
    exp_t sb[$];
    logic [3:0] rp1 = 4'd0;

    function automatic logic [3:0] rom_val(input int a);
        if (rom_mode == 0) return 4'(a);
        return a[0] ? 4'(a) : 4'd0;
    endfunction

    // ROM with two cycles of read latency.
    always @(posedge clk) begin
        rp1            <= rom_val(int'(bus_if.addr));
        bus_if.data_in <= rp1;
    end

    always @(posedge clk) if (bus_if.done === 1'b1) done_cnt <= done_cnt + 1;

    function automatic int exp_addr(input int line, input int k);
        int col, row;
        col = k / c_sxs;
        row = line / c_sys;
        if (c_fh) col = 7 - col;
        if (c_fv) row = 7 - row;
        return c_fr * 64 + row * 8 + col;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic begin_sprite(input int sprx, input int sxs, input int sys,
                                input bit fh, input bit fv, input int fr);
        bus_if.sprx    = 16'(sprx);
        bus_if.scale_x = 3'(sxs);
        bus_if.scale_y = 3'(sys);
        bus_if.flip_h  = fh;
        bus_if.flip_v  = fv;
        bus_if.frame   = 2'(fr);
        c_sprx = sprx;
        c_sxs  = (sxs == 0) ? 1 : sxs;
        c_sys  = (sys == 0) ? 1 : sys;
        c_fh   = fh;
        c_fv   = fv;
        c_fr   = fr;
        @(posedge clk); #1;
        bus_if.sx = '0; bus_if.line_end = 1'b0; bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("busy_after_start", bus_if.busy, 1);
        done_base = done_cnt;
    endtask

    task automatic run_line(input int line, input bit skip, input bit le, input int start_at);
        for (int x = 0; x < LINE_LEN; x++) begin
            exp_t e;
            int   i, k;
            logic [3:0] v;
            @(posedge clk); #1;
            bus_if.sx       = 16'(x);
            bus_if.line_end = le && (x == LINE_LEN - 1);
            bus_if.start    = (x == start_at);
            i = x - c_sprx;
            k = x - (c_sprx - LAT - 1);
            e.pd = 5'd0; e.chk_a = 1'b0; e.a = 8'd0;
            if (!skip && i >= 0 && i < 8 * c_sxs) begin
                v    = rom_val(exp_addr(line, i));
                e.pd = {v != 4'd0, v};
            end
            if (!skip && k >= 0 && k < 8 * c_sxs) begin
                e.chk_a = 1'b1;
                e.a     = 8'(exp_addr(line, k));
            end
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            check($sformatf("pix L%0d sx%0d", line, x), {bus_if.drawing, bus_if.pix}, e.pd);
            if (e.chk_a) check($sformatf("addr L%0d sx%0d", line, x), bus_if.addr, e.a);
        end
        bus_if.start = 1'b0;
    endtask

    task automatic finish_sprite(input string tag);
        repeat (4) begin
            @(posedge clk); #1;
            bus_if.sx = '0; bus_if.line_end = 1'b0;
        end
        @(negedge clk);
        check({tag, "_done_pulses"}, done_cnt - done_base, 1);
        check({tag, "_busy_end"}, bus_if.busy, 0);
    endtask

    task automatic run_sprite(input string tag, input int sprx, input int sxs, input int sys,
                              input bit fh, input bit fv, input int fr, input bit skip,
                              input int busy_start_line);
        int sy;
        sy = (sys == 0) ? 1 : sys;
        begin_sprite(sprx, sxs, sys, fh, fv, fr);
        for (int l = 0; l < 8 * sy; l++)
            run_line(l, skip, skip, (l == busy_start_line) ? 50 : -1);
        finish_sprite(tag);
    endtask

    initial begin
        bus_if.start    = 1'b0;
        bus_if.enable   = 1'b1;
        bus_if.line_end = 1'b0;
        bus_if.sx       = '0;
        bus_if.sprx     = 16'sd100;
        bus_if.frame    = '0;
        bus_if.flip_h   = 1'b0;
        bus_if.flip_v   = 1'b0;
        bus_if.scale_x  = 3'd1;
        bus_if.scale_y  = 3'd1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_addr",    bus_if.addr,    0);
        check("rst_pix",     bus_if.pix,     0);
        check("rst_drawing", bus_if.drawing, 0);
        check("rst_busy",    bus_if.busy,    0);
        check("rst_done",    bus_if.done,    0);
        rst_n = 1'b1;

        // start ignored while enable is low
        bus_if.enable = 1'b0;
        @(posedge clk); #1 bus_if.start = 1'b1;
        @(posedge clk); #1 bus_if.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("disabled_busy", bus_if.busy, 0);
        bus_if.enable = 1'b1;

        rom_mode = 0;
        run_sprite("basic",  100, 1, 1, 1'b0, 1'b0, 0, 1'b0, 3);
        run_sprite("scaled", 100, 2, 3, 1'b0, 1'b0, 0, 1'b0, -1);
        run_sprite("flip",   100, 1, 1, 1'b1, 1'b1, 2, 1'b0, -1);
        rom_mode = 1;
        run_sprite("transp", 100, 1, 1, 1'b0, 1'b0, 0, 1'b0, -1);
        rom_mode = 0;
        run_sprite("skip",   1,   1, 1, 1'b0, 1'b0, 0, 1'b1, -1);

        // asynchronous reset while drawing row 0
        begin_sprite(100, 1, 1, 1'b0, 1'b0, 0);
        for (int x = 0; x <= 100; x++) begin
            @(posedge clk); #1 bus_if.sx = 16'(x);
        end
        @(posedge clk); #1 bus_if.sx = 16'sd101;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_addr",    bus_if.addr,    0);
        check("midrst_pix",     bus_if.pix,     0);
        check("midrst_drawing", bus_if.drawing, 0);
        check("midrst_busy",    bus_if.busy,    0);
        check("midrst_done",    bus_if.done,    0);
        @(posedge clk); #1 rst_n = 1'b1;
        run_sprite("after_rst", 100, 1, 1, 1'b0, 1'b0, 0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
